// File: rtl/fib_pkg.sv
// Shared types and default sizes for the Fibonacci sequencer.
package fib_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      DONE = 2'd2
   } fib_state_e;

   localparam int FIB_WIDTH = 8;
   localparam int FIB_CNT_W = 5;

endpackage

// File: rtl/fib_core.sv
// Fibonacci datapath: prev/cur pair, cleared to (1,0) and advanced one term per step.
module fib_core
   import fib_pkg::*;
#(
   parameter int WIDTH = FIB_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             step,
   output logic [WIDTH-1:0] cur,
   output logic             nxt_carry
);

   logic [WIDTH-1:0] prev_reg;
   logic [WIDTH-1:0] cur_reg;
   logic [WIDTH:0]   sum_next;

   // One extra bit so a carry out of WIDTH bits is visible before it is committed.
   assign sum_next  = {1'b0, prev_reg} + {1'b0, cur_reg};
   assign nxt_carry = sum_next[WIDTH];
   assign cur       = cur_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_reg <= WIDTH'(1);
         cur_reg  <= '0;
      end else if (clr) begin
         prev_reg <= WIDTH'(1);
         cur_reg  <= '0;
      end else if (step) begin
         prev_reg <= cur_reg;
         cur_reg  <= sum_next[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/fib_seq_ctrl.sv
// Start/done sequencer streaming Fibonacci terms over valid/ready; stops early on overflow.
// Define FIB_INDEX_OUT_EN to add the term_idx output (zero-based index of the current term).
module fib_seq_ctrl
   import fib_pkg::*;
#(
   parameter int WIDTH = FIB_WIDTH,
   parameter int CNT_W = FIB_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] n_terms,
   output logic [WIDTH-1:0] term,
   output logic             term_valid,
   input  logic             term_ready,
   output logic             busy,
   output logic             done,
`ifdef FIB_INDEX_OUT_EN
   output logic             ovf,
   output logic [CNT_W-1:0] term_idx
`else
   output logic             ovf
`endif
);

   fib_state_e       state_reg;
   logic [CNT_W-1:0] remaining_reg;
   logic             valid_reg;
   logic             done_reg;
   logic             ovf_reg;
   logic             nxt_carry;
   logic             handshake;
   logic             last_term;
   logic             core_clr;
   logic             core_step;

   assign handshake = (state_reg == EMIT) && valid_reg && term_ready;
   assign last_term = (remaining_reg == CNT_W'(1));
   assign core_clr  = (state_reg == IDLE) && start;
   // The last term never advances the datapath, so an overflow there is harmless.
   assign core_step = handshake && !last_term && !nxt_carry;

   fib_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (core_clr),
      .step     (core_step),
      .cur      (term),
      .nxt_carry(nxt_carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         remaining_reg <= '0;
         valid_reg     <= 1'b0;
         done_reg      <= 1'b0;
         ovf_reg       <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  ovf_reg <= 1'b0;
                  if (n_terms != '0) begin
                     state_reg     <= EMIT;
                     remaining_reg <= n_terms;
                     valid_reg     <= 1'b1;
                  end else begin
                     state_reg <= DONE;
                     done_reg  <= 1'b1;
                  end
               end
            end
            EMIT: begin
               if (handshake) begin
                  if (last_term) begin
                     state_reg <= DONE;
                     valid_reg <= 1'b0;
                     done_reg  <= 1'b1;
                  end else if (nxt_carry) begin
                     state_reg <= DONE;
                     valid_reg <= 1'b0;
                     done_reg  <= 1'b1;
                     ovf_reg   <= 1'b1;
                  end else begin
                     remaining_reg <= remaining_reg - CNT_W'(1);
                  end
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
               valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign term_valid = valid_reg;
   assign done       = done_reg;
   assign ovf        = ovf_reg;
   assign busy       = (state_reg != IDLE);

`ifdef FIB_INDEX_OUT_EN
   logic [CNT_W-1:0] idx_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_reg <= '0;
      end else if (state_reg != EMIT) begin
         idx_reg <= '0;
      end else if (core_step) begin
         idx_reg <= idx_reg + CNT_W'(1);
      end
   end

   assign term_idx = idx_reg;
`else
   // Without the index option there is no index register to keep.
`endif

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Directed bench for fib_seq_ctrl at WIDTH=4, CNT_W=5; outputs sampled on the falling edge.
module tb_fib_seq_ctrl;

   localparam int WIDTH = 4;
   localparam int CNT_W = 5;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] n_terms = '0;
   logic [WIDTH-1:0] term;
   logic             term_valid;
   logic             term_ready = 1'b0;
   logic             busy;
   logic             done;
   logic             ovf;
`ifdef FIB_INDEX_OUT_EN
   logic [CNT_W-1:0] term_idx;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fib_seq_ctrl #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .n_terms   (n_terms),
      .term      (term),
      .term_valid(term_valid),
      .term_ready(term_ready),
      .busy      (busy),
      .done      (done),
`ifdef FIB_INDEX_OUT_EN
      .ovf       (ovf),
      .term_idx  (term_idx)
`else
      .ovf       (ovf)
`endif
   );

   // Pulse start for one cycle; on return the DUT has sampled it and we sit at a falling edge.
   task automatic kick(input int n);
      start   = 1'b1;
      n_terms = CNT_W'(n);
      @(negedge clk);
      start   = 1'b0;
      n_terms = '0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #1;
      checks++;
      if (term_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0 || term !== 4'd0) begin
         errors++;
         $display("FAIL reset_state: valid=%b busy=%b done=%b ovf=%b term=%0d, required all 0",
                  term_valid, busy, done, ovf, term);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      $display("test_reset: outputs idle after reset");
   endtask

   task automatic test_basic;
      int exp_t[7] = '{0, 1, 1, 2, 3, 5, 8};
      term_ready = 1'b1;
      kick(7);
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (term_valid !== 1'b1 || term !== WIDTH'(exp_t[i]) || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_term%0d: valid=%b term=%0d busy=%b, required valid=1 term=%0d busy=1",
                     i, term_valid, term, busy, exp_t[i]);
         end
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1 || term_valid !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL basic_done: done=%b valid=%b ovf=%b, required done=1 valid=0 ovf=0",
                  done, term_valid, ovf);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_idle: done=%b busy=%b, required 0 0", done, busy);
      end
      $display("test_basic: 7 terms streamed, done pulsed");
   endtask

   task automatic test_overflow;
      int exp_t[8] = '{0, 1, 1, 2, 3, 5, 8, 13};
      term_ready = 1'b1;
      kick(10);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (term_valid !== 1'b1 || term !== WIDTH'(exp_t[i])) begin
            errors++;
            $display("FAIL ovf_term%0d: valid=%b term=%0d, required valid=1 term=%0d",
                     i, term_valid, term, exp_t[i]);
         end
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1 || term_valid !== 1'b0 || ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_done: done=%b valid=%b ovf=%b, required done=1 valid=0 ovf=1",
                  done, term_valid, ovf);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (ovf !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL ovf_sticky: ovf=%b busy=%b done=%b, required ovf=1 busy=0 done=0",
                  ovf, busy, done);
      end
      $display("test_overflow: run stopped after 13, ovf sticky");
   endtask

   task automatic test_backpressure;
      int exp_t[5] = '{0, 1, 1, 2, 3};
      term_ready = 1'b1;
      kick(5);
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL bp_ovf_clear: ovf=%b, required 0", ovf);
      end
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            term_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               @(negedge clk);
               checks++;
               if (term_valid !== 1'b1 || term !== 4'd1) begin
                  errors++;
                  $display("FAIL bp_hold%0d: valid=%b term=%0d, required valid=1 term=1",
                           s, term_valid, term);
               end
            end
            term_ready = 1'b1;
         end
         checks++;
         if (term_valid !== 1'b1 || term !== WIDTH'(exp_t[i])) begin
            errors++;
            $display("FAIL bp_term%0d: valid=%b term=%0d, required valid=1 term=%0d",
                     i, term_valid, term, exp_t[i]);
         end
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL bp_done: done=%b ovf=%b, required done=1 ovf=0", done, ovf);
      end
      @(negedge clk);
      $display("test_backpressure: term held 3 stalled cycles, run resumed");
   endtask

   task automatic test_zero_terms;
      term_ready = 1'b1;
      kick(0);
      checks++;
      if (done !== 1'b1 || busy !== 1'b1 || term_valid !== 1'b0) begin
         errors++;
         $display("FAIL zero_done: done=%b busy=%b valid=%b, required 1 1 0", done, busy, term_valid);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || term_valid !== 1'b0) begin
         errors++;
         $display("FAIL zero_idle: done=%b busy=%b valid=%b, required 0 0 0", done, busy, term_valid);
      end
      $display("test_zero_terms: done without terms");
   endtask

   task automatic test_start_while_busy;
      int exp_t[7] = '{0, 1, 1, 2, 3, 5, 8};
      term_ready = 1'b1;
      kick(7);
      for (int i = 0; i < 7; i++) begin
         start   = (i == 2);
         n_terms = (i == 2) ? CNT_W'(3) : '0;
         checks++;
         if (term_valid !== 1'b1 || term !== WIDTH'(exp_t[i])) begin
            errors++;
            $display("FAIL busy_term%0d: valid=%b term=%0d, required valid=1 term=%0d",
                     i, term_valid, term, exp_t[i]);
         end
         @(negedge clk);
      end
      start   = 1'b0;
      n_terms = '0;
      checks++;
      if (done !== 1'b1 || term_valid !== 1'b0) begin
         errors++;
         $display("FAIL busy_done: done=%b valid=%b, required 1 0", done, term_valid);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_idle: busy=%b, required 0", busy);
      end
      $display("test_start_while_busy: second start ignored");
   endtask

   task automatic test_reset_mid_run;
      int exp_t[3] = '{0, 1, 1};
      term_ready = 1'b1;
      kick(7);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (term_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL midrst_state: valid=%b busy=%b done=%b ovf=%b, required all 0",
                  term_valid, busy, done, ovf);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL midrst_nodone: done=%b, required 0", done);
      end
      rst_n = 1'b1;
      @(negedge clk);
      kick(3);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (term_valid !== 1'b1 || term !== WIDTH'(exp_t[i])) begin
            errors++;
            $display("FAIL midrst_term%0d: valid=%b term=%0d, required valid=1 term=%0d",
                     i, term_valid, term, exp_t[i]);
         end
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL midrst_done: done=%b, required 1", done);
      end
      @(negedge clk);
      $display("test_reset_mid_run: aborted run, fresh run from 0");
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_overflow();
      test_backpressure();
      test_zero_terms();
      test_start_while_busy();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
